// File: rtl/vga_sprite_engine_if.sv
// Signal bundle between the VGA timing/background path and the sprite engine.
// Pixels stream at one per clk with no backpressure: active qualifies x/y, and rgb/sel/collide are registered outputs.
interface vga_sprite_engine_if #(
  parameter int COORD_BITS = 10,
  parameter int N_SPRITES  = 4,
  parameter int COLOR_BITS = 12,
  parameter int SEL_BITS   = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
);
  logic                            btn_up;
  logic                            btn_down;
  logic                            btn_left;
  logic                            btn_right;
  logic                            btn_sel;
  logic                            active;
  logic                            screen_end;
  logic [COORD_BITS-1:0]           x;
  logic [COORD_BITS-1:0]           y;
  logic [COLOR_BITS-1:0]           bg_color;
  logic [N_SPRITES*COLOR_BITS-1:0] sprite_color;
  logic [COLOR_BITS-1:0]           rgb;
  logic [SEL_BITS-1:0]             sel;
  logic                            collide;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel,
    output active, screen_end, x, y, bg_color, sprite_color,
    input  rgb, sel, collide
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel,
    input  active, screen_end, x, y, bg_color, sprite_color,
    output rgb, sel, collide
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// Multi-sprite overlay: moves the selected sprite once per frame, reports overlap,
// and composites sprites over the background with output latency matched to bg_color.
module vga_sprite_engine #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int COORD_BITS = 10,
  parameter int N_SPRITES  = 4,
  parameter int SIZE       = 50,
  parameter int STEP       = 1,
  parameter int COLOR_BITS = 12,
  parameter int BG_LATENCY = 2
) (
  input logic                clk,
  input logic                reset,
  vga_sprite_engine_if.slave bus
);
  localparam int SEL_BITS = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int CW       = COORD_BITS + 1;
  localparam logic [CW-1:0] X_MAX  = CW'(WIDTH - SIZE);
  localparam logic [CW-1:0] Y_MAX  = CW'(HEIGHT - SIZE);
  localparam logic [CW-1:0] STEP_W = CW'(STEP);
  localparam logic [CW-1:0] SIZE_W = CW'(SIZE);
  localparam logic [CW-1:0] LAST_W = CW'(SIZE - 1);

  typedef struct packed {
    logic                act;
    logic                hit;
    logic                inv;
    logic [SEL_BITS-1:0] idx;
  } pix_t;

  logic [COORD_BITS-1:0] pos_x [N_SPRITES];
  logic [COORD_BITS-1:0] pos_y [N_SPRITES];
  logic [SEL_BITS-1:0]   sel_r;
  logic                  btn_sel_q;
  logic                  collide_r;
  logic [COLOR_BITS-1:0] rgb_r;

  // Next position of the selected sprite, clamped in CW bits so it never wraps
  logic [CW-1:0] cur_x, cur_y, nxt_x, nxt_y;
  always_comb begin
    cur_x = {1'b0, pos_x[sel_r]};
    cur_y = {1'b0, pos_y[sel_r]};
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (bus.btn_right && !bus.btn_left)
      nxt_x = (cur_x + STEP_W > X_MAX) ? X_MAX : cur_x + STEP_W;
    else if (bus.btn_left && !bus.btn_right)
      nxt_x = (cur_x >= STEP_W) ? cur_x - STEP_W : '0;
    if (bus.btn_down && !bus.btn_up)
      nxt_y = (cur_y + STEP_W > Y_MAX) ? Y_MAX : cur_y + STEP_W;
    else if (bus.btn_up && !bus.btn_down)
      nxt_y = (cur_y >= STEP_W) ? cur_y - STEP_W : '0;
  end

  logic                  overlap;
  logic [COORD_BITS-1:0] dx, dy;
  always_comb begin
    overlap = 1'b0;
    dx      = '0;
    dy      = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      for (int j = i + 1; j < N_SPRITES; j++) begin
        dx = (pos_x[i] >= pos_x[j]) ? pos_x[i] - pos_x[j] : pos_x[j] - pos_x[i];
        dy = (pos_y[i] >= pos_y[j]) ? pos_y[i] - pos_y[j] : pos_y[j] - pos_y[i];
        if ({1'b0, dx} < SIZE_W && {1'b0, dy} < SIZE_W) overlap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        pos_x[i] <= COORD_BITS'(100 + 64 * i);
        pos_y[i] <= COORD_BITS'(100);
      end
      sel_r     <= '0;
      btn_sel_q <= 1'b0;
      collide_r <= 1'b0;
    end else begin
      btn_sel_q <= bus.btn_sel;
      // Move uses the pre-edge sel, so a coincident selection edge moves the old sprite
      if (bus.screen_end) begin
        collide_r    <= overlap;
        pos_x[sel_r] <= nxt_x[COORD_BITS-1:0];
        pos_y[sel_r] <= nxt_y[COORD_BITS-1:0];
      end
      if (bus.btn_sel && !btn_sel_q)
        sel_r <= (sel_r == SEL_BITS'(N_SPRITES - 1)) ? '0 : sel_r + 1'b1;
    end
  end

  // Hit test; descending scan lets the lowest index win
  pix_t          pix_now;
  logic [CW-1:0] xe, ye, px, py;
  always_comb begin
    pix_now     = '0;
    pix_now.act = bus.active;
    xe          = {1'b0, bus.x};
    ye          = {1'b0, bus.y};
    px          = '0;
    py          = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      px = {1'b0, pos_x[i]};
      py = {1'b0, pos_y[i]};
      if (xe >= px && xe < px + SIZE_W && ye >= py && ye < py + SIZE_W) begin
        pix_now.hit = 1'b1;
        pix_now.idx = SEL_BITS'(i);
        pix_now.inv = (SEL_BITS'(i) == sel_r) &&
                      (xe == px || xe == px + LAST_W || ye == py || ye == py + LAST_W);
      end
    end
  end

  pix_t tap;
  generate
    if (BG_LATENCY == 1) begin : g_direct
      assign tap = pix_now;
    end else begin : g_delay
      pix_t dly [BG_LATENCY-1];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < BG_LATENCY - 1; k++) dly[k] <= '0;
        end else begin
          dly[0] <= pix_now;
          for (int k = 1; k < BG_LATENCY - 1; k++) dly[k] <= dly[k-1];
        end
      end
      assign tap = dly[BG_LATENCY-2];
    end
  endgenerate

  logic [COLOR_BITS-1:0] spr_c, rgb_next;
  always_comb begin
    spr_c = '0;
    for (int i = 0; i < N_SPRITES; i++)
      if (tap.idx == SEL_BITS'(i)) spr_c = bus.sprite_color[i*COLOR_BITS +: COLOR_BITS];
    if (!tap.act)      rgb_next = '0;
    else if (!tap.hit) rgb_next = bus.bg_color;
    else if (tap.inv)  rgb_next = ~spr_c;
    else               rgb_next = spr_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb_r <= '0;
    else        rgb_r <= rgb_next;
  end

  assign bus.rgb     = rgb_r;
  assign bus.sel     = sel_r;
  assign bus.collide = collide_r;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: spec-level model of positions, selection and
// compositing checked every cycle, plus hand-computed pixel expectations.
module tb_vga_sprite_engine;
  localparam int N     = 4;
  localparam int SIZE  = 50;
  localparam int CB    = 12;
  localparam int SCW   = N * CB;
  localparam int X_MAX = 640 - SIZE;
  localparam int Y_MAX = 480 - SIZE;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_sprite_engine_if #(.COORD_BITS(10), .N_SPRITES(N), .COLOR_BITS(CB)) bus ();

  vga_sprite_engine #(
    .WIDTH(640), .HEIGHT(480), .COORD_BITS(10), .N_SPRITES(N), .SIZE(SIZE),
    .STEP(1), .COLOR_BITS(CB), .BG_LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must be according to the sprite rules
  logic [CB-1:0] exp_q[$];
  int  mx [N];
  int  my [N];
  int  msel;
  bit  mcol, mprev;
  int  d_idx;
  bit  d_inv, d_act;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [CB-1:0] sc(int i);
    return bus.sprite_color[i*CB +: CB];
  endfunction

  function automatic int absdiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 100 + 64 * i;
      my[i] = 100;
    end
    msel  = 0;
    mcol  = 1'b0;
    mprev = 1'b0;
    d_act = 1'b0;
    d_idx = -1;
    d_inv = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // Called between edges: inputs seen now are what the next edge samples
  task automatic model_step();
    logic [CB-1:0] c;
    int px, py;
    bit hor, ver;
    if (!d_act)         c = '0;
    else if (d_idx < 0) c = bus.bg_color;
    else if (d_inv)     c = ~sc(d_idx);
    else                c = sc(d_idx);
    exp_q.push_back(c);

    px    = int'(bus.x);
    py    = int'(bus.y);
    d_act = bus.active;
    d_idx = -1;
    d_inv = 1'b0;
    for (int i = 0; i < N && d_idx < 0; i++) begin
      if (px >= mx[i] && px < mx[i] + SIZE && py >= my[i] && py < my[i] + SIZE) begin
        d_idx = i;
        d_inv = (i == msel) && (px == mx[i] || px == mx[i] + SIZE - 1 ||
                                py == my[i] || py == my[i] + SIZE - 1);
      end
    end

    if (bus.screen_end) begin
      mcol = 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = i + 1; j < N; j++)
          if (absdiff(mx[i], mx[j]) < SIZE && absdiff(my[i], my[j]) < SIZE) mcol = 1'b1;
      hor = bus.btn_right ^ bus.btn_left;
      ver = bus.btn_down ^ bus.btn_up;
      if (hor) mx[msel] = bus.btn_right ? ((mx[msel] + 1 > X_MAX) ? X_MAX : mx[msel] + 1)
                                        : ((mx[msel] >= 1) ? mx[msel] - 1 : 0);
      if (ver) my[msel] = bus.btn_down ? ((my[msel] + 1 > Y_MAX) ? Y_MAX : my[msel] + 1)
                                       : ((my[msel] >= 1) ? my[msel] - 1 : 0);
    end
    if (bus.btn_sel && !mprev) msel = (msel + 1) % N;
    mprev = bus.btn_sel;
  endtask

  // Single compare process, sampling on the inactive edge
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_rgb", bus.rgb, 0);
      check("reset_sel", bus.sel, 0);
      check("reset_collide", bus.collide, 0);
      model_reset();
    end else begin
      if (exp_q.size() > 0) check("rgb", bus.rgb, exp_q.pop_front());
      check("sel", bus.sel, msel);
      check("collide", bus.collide, mcol);
      model_step();
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pixel_check(string name, int px, int py, logic [CB-1:0] want);
    bus.x      = 10'(px);
    bus.y      = 10'(py);
    bus.active = 1'b1;
    tick(2);
    check(name, bus.rgb, want);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      bus.screen_end = 1'b1;
      tick(1);
      bus.screen_end = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_sel = 0;
    bus.active = 0; bus.screen_end = 0; bus.x = '0; bus.y = '0;
    bus.bg_color     = 12'h555;
    bus.sprite_color = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset position and border highlight of sprite 0
    pixel_check("s0_border", 100, 100, 12'h0FF);
    pixel_check("s0_body", 101, 101, 12'hF00);

    // Right clamp, then left+right cancel
    bus.btn_right = 1;
    frames(600);
    bus.btn_right = 0;
    pixel_check("clamp_left_col", 590, 100, 12'h0FF);
    pixel_check("clamp_outside", 589, 100, 12'h555);
    pixel_check("clamp_corner", 639, 149, 12'h0FF);
    bus.btn_left = 1; bus.btn_right = 1;
    frames(5);
    bus.btn_left = 0; bus.btn_right = 0;
    pixel_check("lr_cancel", 590, 100, 12'h0FF);

    // Mid-frame asynchronous reset
    bus.btn_sel = 1; tick(2); bus.btn_sel = 0; tick(2);
    check("sel_before_reset", bus.sel, 1);
    pixel_check("pre_reset", 600, 120, 12'hF00);
    #1 reset = 1'b0;
    #1;
    check("async_rgb", bus.rgb, 0);
    check("async_sel", bus.sel, 0);
    check("async_collide", bus.collide, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    pixel_check("restored", 100, 100, 12'h0FF);
    pixel_check("old_spot_empty", 590, 100, 12'h555);

    // Selection wrap and held button
    for (int k = 1; k <= 4; k++) begin
      bus.btn_sel = 1; tick(2);
      check("sel_step", bus.sel, k % 4);
      bus.btn_sel = 0; tick(2);
    end
    bus.btn_sel = 1; tick(1000);
    check("sel_held", bus.sel, 1);
    bus.btn_sel = 0; tick(2);

    // Overlap, priority and separation
    bus.btn_left = 1;
    frames(30);
    bus.btn_left = 0;
    frames(1);
    check("collide_set", bus.collide, 1);
    pixel_check("prio_s0", 140, 120, 12'hF00);
    pixel_check("prio_s0_on_s1_edge", 134, 120, 12'hF00);
    pixel_check("s1_body", 150, 120, 12'h0F0);
    pixel_check("s1_border", 183, 120, 12'hF0F);
    bus.btn_right = 1;
    frames(20);
    bus.btn_right = 0;
    frames(1);
    check("collide_clear", bus.collide, 0);

    // Blanking latency and background alignment
    pixel_check("blank_pre", 120, 120, 12'hF00);
    bus.active = 0;
    tick(1);
    check("blank_lag", bus.rgb, 12'hF00);
    tick(1);
    check("blank", bus.rgb, 0);
    bus.bg_color = 12'h123;
    pixel_check("bg_plain", 400, 300, 12'h123);
    bus.bg_color = 12'hABC;
    tick(1);
    check("bg_align", bus.rgb, 12'hABC);

    // Randomised traffic against the model
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        bus.x = 10'($urandom_range(80, 400));
        bus.y = 10'($urandom_range(60, 200));
        hold  = $urandom_range(1, 4);
      end
      hold--;
      bus.active     = ($urandom_range(0, 7) != 0);
      bus.bg_color   = CB'($urandom);
      bus.screen_end = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0)
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'($urandom);
      if ($urandom_range(0, 40) == 0) bus.btn_sel = ~bus.btn_sel;
      if ($urandom_range(0, 200) == 0) bus.sprite_color = SCW'({$urandom, $urandom});
      tick(1);
    end
    bus.screen_end = 0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
